uart_byte_fifo: RTL
===================

// Module: uart_byte_fifo
// PURPOSE
//  Byte FIFO between uart_rx (producer) and uart_tx or a byte consumer, absorbing bursts
//  of received characters while the consumer is busy.
//  Valid/ready on both sides, first-word-fall-through output, drop counter for bytes
//  offered while full. Single clock domain, same clock as the UART baud generators.
// PARAMETERS
//  DEPTH      16  entries; power of two, >= 2
//  DATA_W      8  byte width; fixed at 8 for UART use
//  COUNT_W    $clog2(DEPTH)+1  width of occupancy count (derived, do not override)
// PORTS
//  clock          in   1        system clock
//  resetn         in   1        asynchronous active-low reset
//  in_valid       in   1        upstream byte valid (from uart_rx data_valid)
//  in_ready       out  1        FIFO can accept; = !full
//  in_data        in   DATA_W   upstream byte
//  out_valid      out  1        head byte valid; = !empty
//  out_ready      in   1        downstream accepts head byte
//  out_data       out  DATA_W   head byte (FWFT)
//  count          out  COUNT_W  current occupancy 0..DEPTH
//  drop_count     out  8        saturating count of bytes offered while full
//  drop_clear     in   1        synchronous clear of drop_count
// BEHAVIOUR
//  - Reset (async assert, sync release): wr_ptr=rd_ptr=0, count=0, drop_count=0,
//    in_ready=1, out_valid=0. out_data is don't-care while out_valid=0. Storage not cleared.
//  - Pointers COUNT_W bits wide: full when MSBs differ and low bits equal; empty when equal.
//    The low bits index storage and wrap modulo DEPTH.
//  - Push = in_valid & in_ready: mem[wr_ptr] <= in_data, wr_ptr++ at the clock edge.
//  - Pop = out_valid & out_ready: rd_ptr++ at the clock edge.
//  - Latency: a byte pushed at edge N gives out_valid=1 with that byte after edge N.
//    No same-cycle bypass when empty.
//  - in_ready and out_valid are functions of the registered pointers only.
//    There is no combinational path out_ready->in_ready or in_valid->out_valid.
//  - When full, in_ready=0 even if a pop happens in the same cycle. The freed slot is
//    visible the next cycle.
//  - Simultaneous push and pop when neither full nor empty: both happen, count unchanged.
//  - count update: +1 on push only, -1 on pop only, else held.
//  - Drop: in_valid & !in_ready increments drop_count, saturating at 255.
//    The offered byte is discarded. uart_rx does not hold data, so a drop is data loss.
//  - drop_clear and drop in the same cycle: clear wins, drop_count=0.
//  - out_data stays stable while out_valid=1 and out_ready=0.
//    Pushes never alter the head entry.
//  - Reset mid-operation: all contents are logically discarded immediately
//    (out_valid=0 asynchronously).
// STRUCTURE
//  - uart_pkg (shared): typedef logic [7:0] byte_t; localparams CLOCK_HZ=24_000_000,
//    BAUD_RATE=115200, BAUD_DIVIDER=CLOCK_HZ/BAUD_RATE; used by uart_rx/uart_tx/this block.
//  - One sub-module: uart_fifo_ram, DEPTH x DATA_W.
//    Synchronous write, asynchronous read, no reset, so it maps to distributed RAM.
//  - Pointer/flag/count/drop logic lives in uart_byte_fifo itself.
//  - Integration in uart_system: uart_rx -> uart_byte_fifo -> uart_tx.
//    fifo out_valid/out_data/out_ready connect to uart_tx data_valid/data_bits/data_ready.
// TESTING
//  1. Reset: hold resetn=0 -> in_ready=1, out_valid=0, count=0, drop_count=0.
//     Release, idle 10 cycles -> unchanged.
//  2. Ordered pass-through, out_ready=1: push 0x41,0x42,0x43 on consecutive cycles
//     -> out_data 0x41,0x42,0x43 each one cycle after its push; count returns to 0.
//  3. Fill/overflow, DEPTH=16, out_ready=0: push 0x00..0x0F -> count=16, in_ready=0.
//     Push 0x10,0x11 -> drop_count=2.
//     Then drain -> exactly 0x00..0x0F, then out_valid=0.
//  4. Full + simultaneous pop: from full, assert out_ready and in_valid(0xAA) together
//     -> pop occurs, 0xAA dropped (drop_count+1), count=15.
//     Next cycle 0xAA is accepted, count=15.
//  5. Wrap-around: 40 pushes with random out_ready (seeded), scoreboard
//     -> output order matches input order, count never >16, drop_count=0 when in_valid
//     obeys in_ready.
//  6. drop_count saturation and clear: 300 pushes while full -> drop_count=255.
//     drop_clear with a concurrent drop -> 0.
//     Mid-stream resetn pulse with 5 queued -> out_valid=0 immediately, count=0.

Source files
------------

// File: rtl/uart_byte_fifo_pkg.sv
// Shared UART types and constants used by uart_rx, uart_tx and the byte FIFO.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_byte_fifo_pkg;

    // One UART character.
    typedef logic [7:0] byte_t;

    // Saturating drop counter, one byte wide.
    typedef logic [7:0] drop_cnt_t;

    localparam drop_cnt_t DROP_MAX = 8'hFF;

    // Baud generation shared by uart_rx / uart_tx. The FIFO runs on this same clock.
    localparam int CLOCK_HZ     = 24_000_000;
    localparam int BAUD_RATE    = 115_200;
    localparam int BAUD_DIVIDER = CLOCK_HZ / BAUD_RATE;

    // Default FIFO geometry for uart_system.
    localparam int FIFO_DEPTH  = 16;
    localparam int FIFO_DATA_W = 8;

endpackage

// File: rtl/uart_byte_fifo_if.sv
// Byte stream bundle between uart_rx, the byte FIFO and its consumer (uart_tx).
// Latency: n/a (wires only).
// Backpressure: valid/ready on both sides; in_ready/out_valid are driven by the FIFO.
//
// Signals
//  in_valid/in_ready/in_data     producer side (uart_rx -> FIFO)
//  out_valid/out_ready/out_data  consumer side (FIFO -> uart_tx), head byte is FWFT
//  count                         occupancy 0..DEPTH
//  drop_count/drop_clear         saturating lost-byte counter and its clear
interface uart_byte_fifo_if #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
);
    import uart_byte_fifo_pkg::*;

    localparam int COUNT_W = $clog2(DEPTH) + 1;

    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  in_data;

    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_data;

    logic [COUNT_W-1:0] count;
    drop_cnt_t          drop_count;
    logic               drop_clear;

    // Environment side: producer, consumer and status observer.
    modport master (
        output in_valid, in_data, out_ready, drop_clear,
        input  in_ready, out_valid, out_data, count, drop_count
    );

    // FIFO side.
    modport slave (
        input  in_valid, in_data, out_ready, drop_clear,
        output in_ready, out_valid, out_data, count, drop_count
    );

endinterface

// File: rtl/uart_byte_fifo_ram.sv
// DEPTH x DATA_W storage for the byte FIFO: synchronous write, asynchronous read.
// Latency: write visible on rd_data the cycle after the write edge; read is combinational.
// Backpressure: none; the FIFO controller never writes the slot being read.
//
// Ports
//  clock               write clock
//  wr_en/wr_addr/wr_data  write port
//  rd_addr/rd_data        combinational read port
// No reset on the array so it maps onto distributed RAM.
module uart_byte_fifo_ram #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_byte_fifo.sv
// Byte FIFO absorbing uart_rx bursts ahead of a slower consumer; counts bytes lost when full.
// Latency: byte pushed at edge N is presented (out_valid/out_data) right after edge N, no bypass.
// Backpressure: in_ready = !full from registered pointers only; offers while full are dropped and counted.
//
// Ports
//  clock, resetn   core clock, asynchronous active-low reset
//  bus (slave)     in_*/out_* valid-ready byte streams, count, drop_count, drop_clear
module uart_byte_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic             clock,
    input  logic             resetn,
    uart_byte_fifo_if.slave  bus
);
    import uart_byte_fifo_pkg::*;

    localparam int ADDR_W  = $clog2(DEPTH);
    localparam int COUNT_W = ADDR_W + 1;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("uart_byte_fifo: DEPTH must be a power of two >= 2");
    end

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // without a separate flag; the low bits address the RAM.
    logic [COUNT_W-1:0] wr_ptr;
    logic [COUNT_W-1:0] rd_ptr;
    logic [COUNT_W-1:0] occupancy;
    drop_cnt_t          drops;

    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic               drop;
    logic [DATA_W-1:0]  head_data;

    // Flags depend on the registered pointers only, so neither out_ready nor
    // in_valid has a combinational path to the opposite handshake.
    // A pop in the same cycle as full does not open in_ready; that slot is
    // offered one cycle later.
    always_comb begin
        full  = (wr_ptr[COUNT_W-1] != rd_ptr[COUNT_W-1]) &&
                (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
        empty = (wr_ptr == rd_ptr);
        push  = bus.in_valid  & ~full;
        pop   = bus.out_ready & ~empty;
        drop  = bus.in_valid  &  full;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rd_ptr <= '0;
        end else if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Explicit occupancy register: a push and a pop together leave it unchanged.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            occupancy <= '0;
        end else begin
            case ({push, pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    // uart_rx cannot stall, so every refused byte is lost; count them.
    // Clear takes priority over a drop in the same cycle.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            drops <= '0;
        end else if (bus.drop_clear) begin
            drops <= '0;
        end else if (drop && (drops != DROP_MAX)) begin
            drops <= drops + 8'd1;
        end
    end

    // Writes only ever land on the slot at wr_ptr, which is never the head
    // while the FIFO holds data (full blocks the write), so out_data is stable
    // while the consumer stalls.
    uart_byte_fifo_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clock   (clock),
        .wr_en   (push),
        .wr_addr (wr_ptr[ADDR_W-1:0]),
        .wr_data (bus.in_data),
        .rd_addr (rd_ptr[ADDR_W-1:0]),
        .rd_data (head_data)
    );

    assign bus.in_ready   = ~full;
    assign bus.out_valid  = ~empty;
    assign bus.out_data   = head_data;
    assign bus.count      = occupancy;
    assign bus.drop_count = drops;

endmodule
